// File: rtl/vga_layer_compositor.sv
// Priority compositor for NUM_LAYERS VGA pixel layers with colour keying, frame-synchronous config.
// Optional per-layer 50% blend with the next lower layer: define VGA_LAYER_BLEND_EN.
module vga_layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int MEM_LAT    = 2,
    parameter int FCNT_W     = 16
) (
    input  logic                          pixel_clk,
    input  logic                          rst,
    input  logic                          blank_in,
    input  logic                          hs_in,
    input  logic                          vs_in,
    input  logic [10:0]                   drawX,
    input  logic [10:0]                   drawY,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pix,
    input  logic [NUM_LAYERS-1:0]         cfg_en,
    input  logic [NUM_LAYERS-1:0]         cfg_blend,
    input  logic [COLOR_W-1:0]            cfg_key,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    output logic                          hs,
    output logic                          vs,
    output logic [COLOR_W-1:0]            RGB,
    output logic                          frame_clk,
    output logic [FCNT_W-1:0]             frame_count
);
    localparam int D = MEM_LAT + 1;

    logic [D-1:0]            blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
    logic [COLOR_W-1:0]      rgb_q, rgb_d;
    logic                    frame_clk_q, frame_clk_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic [NUM_LAYERS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic [COLOR_W-1:0]      pend_key_q, pend_key_d, act_key_q, act_key_d;
    logic [COLOR_W-1:0]      pix, win, lower;
    logic                    unused_inputs;

`ifdef VGA_LAYER_BLEND_EN
    localparam int NCH = COLOR_W / 4;
    logic [NUM_LAYERS-1:0]   pend_blend_q, pend_blend_d, act_blend_q, act_blend_d;
    logic                    win_blend;
    logic [4:0]              sum;
    assign unused_inputs = ^{drawX, drawY};
`else
    assign unused_inputs = ^{drawX, drawY, cfg_blend};
`endif

    always_comb begin
        blank_d     = {blank_q[D-2:0], blank_in};
        hs_d        = {hs_q[D-2:0], hs_in};
        vs_d        = {vs_q[D-2:0], vs_in};
        // Registered fall detect: high in the same cycle the output vs first reads 0.
        frame_clk_d = vs_q[D-1] & ~vs_q[D-2];
        fcnt_d      = frame_clk_q ? fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1} : fcnt_q;

        cfg_ready_d = cfg_ready_q;
        pend_en_d   = pend_en_q;
        pend_key_d  = pend_key_q;
        act_en_d    = act_en_q;
        act_key_d   = act_key_q;
`ifdef VGA_LAYER_BLEND_EN
        pend_blend_d = pend_blend_q;
        act_blend_d  = act_blend_q;
`endif
        // cfg_ready low means the pending set holds an unapplied configuration.
        if (frame_clk_q && !cfg_ready_q) begin
            act_en_d    = pend_en_q;
            act_key_d   = pend_key_q;
`ifdef VGA_LAYER_BLEND_EN
            act_blend_d = pend_blend_q;
`endif
            cfg_ready_d = 1'b1;
        end
        if (cfg_valid && cfg_ready_q) begin
            pend_en_d    = cfg_en;
            pend_key_d   = cfg_key;
`ifdef VGA_LAYER_BLEND_EN
            pend_blend_d = cfg_blend;
`endif
            cfg_ready_d  = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        pix   = '0;
        win   = '0;
        lower = '0;
`ifdef VGA_LAYER_BLEND_EN
        win_blend = 1'b0;
        sum       = '0;
`endif
        for (int i = 0; i < NUM_LAYERS; i++) begin
            pix = layer_pix[i*COLOR_W +: COLOR_W];
            if (act_en_q[i] && (pix != act_key_q)) begin
                lower = win;
                win   = pix;
`ifdef VGA_LAYER_BLEND_EN
                win_blend = act_blend_q[i];
`endif
            end
        end
        rgb_d = win;
`ifdef VGA_LAYER_BLEND_EN
        // A missing lower layer contributes black to the average.
        if (win_blend) begin
            for (int c = 0; c < NCH; c++) begin
                sum = {1'b0, win[c*4 +: 4]} + {1'b0, lower[c*4 +: 4]};
                rgb_d[c*4 +: 4] = sum[4:1];
            end
        end
`endif
        if (blank_q[MEM_LAT-1]) rgb_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            blank_q     <= '1;
            hs_q        <= '1;
            vs_q        <= '1;
            rgb_q       <= '0;
            frame_clk_q <= 1'b0;
            fcnt_q      <= '0;
            cfg_ready_q <= 1'b1;
            pend_en_q   <= '1;
            pend_key_q  <= '0;
            act_en_q    <= '1;
            act_key_q   <= '0;
`ifdef VGA_LAYER_BLEND_EN
            pend_blend_q <= '0;
            act_blend_q  <= '0;
`endif
        end else begin
            blank_q     <= blank_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
            frame_clk_q <= frame_clk_d;
            fcnt_q      <= fcnt_d;
            cfg_ready_q <= cfg_ready_d;
            pend_en_q   <= pend_en_d;
            pend_key_q  <= pend_key_d;
            act_en_q    <= act_en_d;
            act_key_q   <= act_key_d;
`ifdef VGA_LAYER_BLEND_EN
            pend_blend_q <= pend_blend_d;
            act_blend_q  <= act_blend_d;
`endif
        end
    end

    assign hs          = hs_q[D-1];
    assign vs          = vs_q[D-1];
    assign RGB         = rgb_q;
    assign frame_clk   = frame_clk_q;
    assign frame_count = fcnt_q;
    assign cfg_ready   = cfg_ready_q;
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor: table of composition vectors plus sync, config and reset sequences.
module tb_vga_layer_compositor;
    localparam int NL = 4;
    localparam int CW = 12;
    localparam int ML = 2;
    localparam int FW = 8;
    localparam int D  = ML + 1;

    logic              pixel_clk = 1'b0;
    logic              rst;
    logic              blank_in, hs_in, vs_in;
    logic [10:0]       drawX, drawY;
    logic [NL*CW-1:0]  pix_req, layer_pix;
    logic [NL*CW-1:0]  src_q [ML];
    logic [NL-1:0]     cfg_en, cfg_blend;
    logic [CW-1:0]     cfg_key;
    logic              cfg_valid, cfg_ready, hs, vs, frame_clk;
    logic [CW-1:0]     RGB;
    logic [FW-1:0]     frame_count;
    logic [FW-1:0]     exp_fc;
    logic [CW-1:0]     prev, exp_blend;
    int                n_tests = 0;
    int                n_fail  = 0;

    typedef struct {
        logic [NL*CW-1:0] pix;
        logic             blank;
        logic [CW-1:0]    exp;
    } vec_t;
    vec_t vecs[6];

    always #5 pixel_clk = ~pixel_clk;

    // Pixel source model: data requested with the timing signals returns ML cycles later.
    always @(posedge pixel_clk) begin
        src_q[0] <= pix_req;
        for (int i = 1; i < ML; i++) src_q[i] <= src_q[i-1];
    end
    assign layer_pix = src_q[ML-1];

    vga_layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .MEM_LAT(ML), .FCNT_W(FW)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .drawX(drawX), .drawY(drawY), .layer_pix(layer_pix), .cfg_en(cfg_en),
        .cfg_blend(cfg_blend), .cfg_key(cfg_key), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .hs(hs), .vs(vs), .RGB(RGB), .frame_clk(frame_clk), .frame_count(frame_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
            drawX = drawX + 11'd1;
        end
    endtask

    task automatic issue_cfg(input logic [NL-1:0] en, input logic [NL-1:0] bl, input logic [CW-1:0] key);
        cfg_en    = en;
        cfg_blend = bl;
        cfg_key   = key;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic frame();
        vs_in = 1'b0;
        tick(1);
        vs_in = 1'b1;
        tick(1);
        exp_fc = exp_fc + 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"},        32'(hs),          32'd1);
        check({tag, "_vs"},        32'(vs),          32'd1);
        check({tag, "_rgb"},       32'(RGB),         32'd0);
        check({tag, "_frame_clk"}, 32'(frame_clk),   32'd0);
        check({tag, "_fcount"},    32'(frame_count), 32'd0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready),   32'd1);
    endtask

    initial begin
        vecs[0] = '{{12'h000, 12'h000, 12'hF00, 12'h0F0}, 1'b0, 12'hF00};
        vecs[1] = '{{12'h000, 12'h000, 12'h000, 12'h000}, 1'b0, 12'h000};
        vecs[2] = '{{12'h123, 12'h000, 12'hF00, 12'h0F0}, 1'b0, 12'h123};
        vecs[3] = '{{12'h000, 12'h0AB, 12'h000, 12'h000}, 1'b0, 12'h0AB};
        vecs[4] = '{{12'h000, 12'h000, 12'h000, 12'h0F0}, 1'b0, 12'h0F0};
        vecs[5] = '{{12'h000, 12'h000, 12'hF00, 12'h0F0}, 1'b1, 12'h000};
`ifdef VGA_LAYER_BLEND_EN
        exp_blend = 12'h770;
`else
        exp_blend = 12'hF00;
`endif

        rst = 1'b1; blank_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        drawX = '0; drawY = '0; pix_req = '0;
        cfg_en = '0; cfg_blend = '0; cfg_key = '0; cfg_valid = 1'b0;
        exp_fc = '0;
        #12;
        check_reset_outputs("por");
        @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < D + 2; n++) begin
            tick(1);
            check("no_frame_clk_after_release", 32'(frame_clk), 32'd0);
        end

        // Composition table: each result must appear exactly D cycles after its request.
        prev = '0;
        for (int v = 0; v < 6; v++) begin
            pix_req  = vecs[v].pix;
            blank_in = vecs[v].blank;
            tick(D - 1);
            check($sformatf("vec%0d_latency_hold", v), 32'(RGB), 32'(prev));
            tick(1);
            check($sformatf("vec%0d_rgb", v), 32'(RGB), 32'(vecs[v].exp));
            prev = vecs[v].exp;
        end

        // Blank pulse of 5 cycles and hs pulse of 3 cycles, both shifted by D.
        pix_req  = {12'h000, 12'h000, 12'hF00, 12'h0F0};
        blank_in = 1'b0;
        tick(D + 1);
        blank_in = 1'b1;
        hs_in    = 1'b0;
        for (int n = 1; n <= D + 7; n++) begin
            tick(1);
            if (n == 5) blank_in = 1'b0;
            if (n == 3) hs_in = 1'b1;
            check($sformatf("blank_pulse_rgb_c%0d", n), 32'(RGB),
                  (n >= D && n <= D + 4) ? 32'h000 : 32'hF00);
            check($sformatf("hs_pulse_c%0d", n), 32'(hs),
                  (n >= D && n <= D + 2) ? 32'd0 : 32'd1);
        end

        // Mid-frame config is held pending; a second request while pending is ignored.
        issue_cfg(4'b0001, 4'b0000, 12'h0F0);
        check("cfg_ready_drops", 32'(cfg_ready), 32'd0);
        issue_cfg(4'b0010, 4'b0000, 12'h000);
        tick(2);
        check("rgb_unchanged_pending", 32'(RGB), 32'hF00);
        vs_in = 1'b0;
        for (int n = 1; n <= D + 2; n++) begin
            tick(1);
            if (n == 1) vs_in = 1'b1;
            if (n == D - 1) begin
                check("vs_before_fall", 32'(vs), 32'd1);
                check("frame_clk_before", 32'(frame_clk), 32'd0);
            end
            if (n == D) begin
                check("vs_fall_delayed", 32'(vs), 32'd0);
                check("frame_clk_pulse", 32'(frame_clk), 32'd1);
                check("cfg_ready_at_frame", 32'(cfg_ready), 32'd0);
                check("rgb_old_at_frame", 32'(RGB), 32'hF00);
            end
            if (n == D + 1) begin
                check("vs_rise_delayed", 32'(vs), 32'd1);
                check("frame_clk_one_cycle", 32'(frame_clk), 32'd0);
                check("cfg_ready_after_frame", 32'(cfg_ready), 32'd1);
                check("frame_count_inc", 32'(frame_count), 32'(exp_fc + 1'b1));
            end
            if (n == D + 2) check("rgb_keyed_new_cfg", 32'(RGB), 32'h000);
        end
        exp_fc = exp_fc + 1'b1;

        // Frame counter wrap.
        while (exp_fc != '1) frame();
        tick(D + 1);
        check("frame_count_all_ones", 32'(frame_count), 32'(exp_fc));
        frame();
        tick(D + 1);
        check("frame_count_wrap", 32'(frame_count), 32'd0);
        check("frame_count_model_wrap", 32'(exp_fc), 32'd0);
        check("rgb_second_cfg_ignored", 32'(RGB), 32'h000);

        // Reset mid-line with a pending config.
        issue_cfg(4'b0001, 4'b0000, 12'h0F0);
        check("cfg_pending_before_rst", 32'(cfg_ready), 32'd0);
        pix_req = {12'h000, 12'h000, 12'hF00, 12'h123};
        hs_in   = 1'b0;
        tick(D + 1);
        check("pre_rst_rgb", 32'(RGB), 32'h123);
        check("pre_rst_hs", 32'(hs), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge pixel_clk);
        #1;
        rst    = 1'b0;
        hs_in  = 1'b1;
        exp_fc = '0;
        for (int n = 0; n < D + 1; n++) begin
            tick(1);
            check("no_frame_clk_after_mid_rst", 32'(frame_clk), 32'd0);
        end
        check("rgb_defaults_after_rst", 32'(RGB), 32'hF00);
        frame();
        tick(D + 1);
        check("pending_dropped_rgb", 32'(RGB), 32'hF00);
        check("pending_dropped_ready", 32'(cfg_ready), 32'd1);
        check("frame_count_after_rst", 32'(frame_count), 32'(exp_fc));

        // Blend of L1 over L0.
        issue_cfg(4'b1111, 4'b0010, 12'h000);
        frame();
        pix_req = {12'h000, 12'h000, 12'hF00, 12'h0F0};
        tick(D + 1);
        check("blend_rgb", 32'(RGB), 32'(exp_blend));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
